// File: rtl/bcd_to_bin_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_to_bin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_ADJ_TH  = 4'd8;
    localparam logic [3:0] DIGIT_ADJ_SUB = 4'd3;
    localparam logic [3:0] DIGIT_MAX     = 4'd9;

    // Smallest w with 2^w >= 10^n; doubles as the number of shift cycles.
    function automatic int bin_width(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        for (int w = 0; w < 32; w++) begin
            if ((longint'(1) << w) >= p) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/result bundle between the BCD source, the converter and the binary consumer.
interface bcd_to_bin_seq_if #(
    parameter int N_DIGITS = 2
);
    import bcd_to_bin_pkg::*;

    localparam int BIN_W = bin_width(N_DIGITS);

    logic [4*N_DIGITS-1:0] in_BCD;
    logic                  in_INIT;
    logic [BIN_W-1:0]      out_BIN;
    logic                  out_BUSY;
    logic                  out_DONE;
    logic                  out_ERR;

    modport master (
        output in_BCD, in_INIT,
        input  out_BIN, out_BUSY, out_DONE, out_ERR
    );

    modport slave (
        input  in_BCD, in_INIT,
        output out_BIN, out_BUSY, out_DONE, out_ERR
    );

endinterface

// File: rtl/bcd_to_bin_seq_digit_adj.sv
// Per-digit correction after a right shift: subtract 3 from any digit >= 8.
// Purely combinational, zero latency, no flow control.
module bcd_digit_adj
    import bcd_to_bin_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= DIGIT_ADJ_TH) ? (i_digit - DIGIT_ADJ_SUB) : i_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// N-digit BCD-to-binary converter by reverse double-dabble, one conversion in flight.
// Result in out_DONE cycle BIN_W edges after accept (invalid input: next cycle); in_INIT ignored while busy.
module bcd_to_bin_seq
    import bcd_to_bin_pkg::*;
#(
    parameter int N_DIGITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    bcd_to_bin_seq_if.slave   bus
);

    localparam int BIN_W = bin_width(N_DIGITS);
    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic [BIN_W-1:0]   r_bin;
    logic [BIN_W-1:0]   w_bin_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [BIN_W-1:0]   r_out_bin;
    logic [BIN_W-1:0]   w_out_bin_nxt;
    logic               r_err;
    logic               w_err_nxt;

    logic [BCD_W+BIN_W-1:0] w_shift;
    logic [BCD_W-1:0]       w_bcd_adj;
    logic                   w_in_bad;

    // The bcd LSB falls into the bin MSB; the vacated bcd MSB fills with zero.
    assign w_shift = {r_bcd, r_bin} >> 1;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (w_shift[BIN_W + 4*g +: 4]),
            .o_digit (w_bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        w_in_bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bus.in_BCD[4*i +: 4] > DIGIT_MAX) w_in_bad = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bcd_nxt     = r_bcd;
        w_bin_nxt     = r_bin;
        w_cnt_nxt     = r_cnt;
        w_out_bin_nxt = r_out_bin;
        w_err_nxt     = r_err;
        case (r_state)
            IDLE: begin
                if (bus.in_INIT) begin
                    w_err_nxt     = w_in_bad;
                    w_out_bin_nxt = '0;
                    w_bin_nxt     = '0;
                    w_cnt_nxt     = '0;
                    if (w_in_bad) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_bcd_nxt   = bus.in_BCD;
                        w_state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_bcd_nxt = w_bcd_adj;
                w_bin_nxt = w_shift[BIN_W-1:0];
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_out_bin_nxt = w_shift[BIN_W-1:0];
                    w_state_nxt   = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_out_bin <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bcd     <= w_bcd_nxt;
            r_bin     <= w_bin_nxt;
            r_cnt     <= w_cnt_nxt;
            r_out_bin <= w_out_bin_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign bus.out_BIN  = r_out_bin;
    assign bus.out_BUSY = (r_state != IDLE);
    assign bus.out_DONE = (r_state == DONE);
    assign bus.out_ERR  = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq at N_DIGITS = 2, 3 and 4 against an arithmetic reference model.
module tb_bcd_to_bin_seq;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_to_bin_seq_if #(.N_DIGITS(2)) b2 ();
    bcd_to_bin_seq_if #(.N_DIGITS(3)) b3 ();
    bcd_to_bin_seq_if #(.N_DIGITS(4)) b4 ();

    bcd_to_bin_seq #(.N_DIGITS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
    bcd_to_bin_seq #(.N_DIGITS(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));
    bcd_to_bin_seq #(.N_DIGITS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int exp_width(input int n);
        case (n)
            1: return 4;
            2: return 7;
            3: return 10;
            4: return 14;
            5: return 17;
            6: return 20;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_err(input int n, input logic [23:0] bcd);
        for (int i = 0; i < n; i++) if (int'(bcd[4*i +: 4]) > 9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int ref_val(input int n, input logic [23:0] bcd);
        int v = 0;
        int m = 1;
        for (int i = 0; i < n; i++) begin
            v = v + int'(bcd[4*i +: 4]) * m;
            m = m * 10;
        end
        return v;
    endfunction

    function automatic logic [23:0] to_bcd(input int val, input int n);
        logic [23:0] r = '0;
        int v = val;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // ---------------- instance access ----------------
    task automatic set_in(input int n, input logic [23:0] bcd, input logic init);
        case (n)
            2: begin b2.in_BCD = bcd[7:0];  b2.in_INIT = init; end
            3: begin b3.in_BCD = bcd[11:0]; b3.in_INIT = init; end
            4: begin b4.in_BCD = bcd[15:0]; b4.in_INIT = init; end
            default: ;
        endcase
    endtask

    function automatic logic done_of(input int n);
        case (n)
            2: return b2.out_DONE;
            3: return b3.out_DONE;
            4: return b4.out_DONE;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic busy_of(input int n);
        case (n)
            2: return b2.out_BUSY;
            3: return b3.out_BUSY;
            4: return b4.out_BUSY;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic err_of(input int n);
        case (n)
            2: return b2.out_ERR;
            3: return b3.out_ERR;
            4: return b4.out_ERR;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] bin_of(input int n);
        case (n)
            2: return 32'(b2.out_BIN);
            3: return 32'(b3.out_BIN);
            4: return 32'(b4.out_BIN);
            default: return 32'd0;
        endcase
    endfunction

    task automatic wait_done(input int n);
        int t = 0;
        while (!done_of(n) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("wait_done_in_time", 32'(t < 40), 32'd1);
    endtask

    // One full conversion; glitch pulses a second start with other data mid-flight.
    task automatic run_conv(input int n, input logic [23:0] bcd, input bit glitch);
        int   lat = 0;
        int   extra = 0;
        bit   busy_ok = 1'b1;
        bit   e_err;
        int   e_bin;
        int   e_lat;
        e_err = ref_err(n, bcd);
        e_bin = e_err ? 0 : ref_val(n, bcd);
        e_lat = e_err ? 0 : exp_width(n);
        @(negedge clk);
        set_in(n, bcd, 1'b1);
        @(negedge clk);
        set_in(n, bcd, 1'b0);
        while (!done_of(n) && lat < 40) begin
            if (!busy_of(n)) busy_ok = 1'b0;
            if (glitch && lat == 2) set_in(n, 24'h555555, 1'b1);
            if (glitch && lat == 3) set_in(n, 24'h555555, 1'b0);
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) begin
            chk("done_timeout", 32'(lat), 32'(e_lat));
            return;
        end
        chk("latency", 32'(lat), 32'(e_lat));
        chk("busy_during_run", 32'(busy_ok), 32'd1);
        chk("busy_in_done", 32'(busy_of(n)), 32'd1);
        chk("bin", bin_of(n), 32'(e_bin));
        chk("err", 32'(err_of(n)), 32'(e_err));
        @(negedge clk);
        chk("done_one_cycle", 32'(done_of(n)), 32'd0);
        chk("idle_not_busy", 32'(busy_of(n)), 32'd0);
        chk("bin_hold", bin_of(n), 32'(e_bin));
        chk("err_hold", 32'(err_of(n)), 32'(e_err));
        if (glitch) begin
            repeat (16) begin
                @(negedge clk);
                if (done_of(n)) extra++;
            end
            chk("no_extra_done", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        logic [23:0] rb;
        int          rn;
        int          extra;
        rst = 1'b1;
        set_in(2, 24'h0, 1'b0);
        set_in(3, 24'h0, 1'b0);
        set_in(4, 24'h0, 1'b0);
        #1;
        for (int n = 2; n <= 4; n++) begin
            chk("rst_bin",  bin_of(n), 32'd0);
            chk("rst_busy", 32'(busy_of(n)), 32'd0);
            chk("rst_done", 32'(done_of(n)), 32'd0);
            chk("rst_err",  32'(err_of(n)), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_conv(2, 24'h000099, 1'b0);
        run_conv(3, 24'h000999, 1'b0);
        run_conv(3, 24'h000000, 1'b0);
        run_conv(4, 24'h009999, 1'b0);
        run_conv(4, 24'h001234, 1'b0);
        run_conv(2, 24'h00001A, 1'b0);
        run_conv(2, 24'h000047, 1'b0);
        run_conv(3, 24'h0009F0, 1'b0);

        // Start request during a conversion is ignored
        run_conv(2, 24'h000083, 1'b1);
        run_conv(4, 24'h008076, 1'b1);

        // in_INIT held high: re-accepted on the first IDLE edge with the new data
        @(negedge clk);
        set_in(2, 24'h000042, 1'b1);
        @(negedge clk);
        set_in(2, 24'h000017, 1'b1);
        wait_done(2);
        chk("b2b_first_bin", bin_of(2), 32'd42);
        @(negedge clk);
        chk("b2b_idle_gap", 32'(busy_of(2)), 32'd0);
        @(negedge clk);
        chk("b2b_reaccept_busy", 32'(busy_of(2)), 32'd1);
        chk("b2b_bin_cleared", bin_of(2), 32'd0);
        set_in(2, 24'h000017, 1'b0);
        wait_done(2);
        chk("b2b_second_bin", bin_of(2), 32'd17);
        @(negedge clk);

        // Reset clears a held error, and abandons a conversion in flight
        run_conv(2, 24'h0000C5, 1'b0);
        @(negedge clk);
        set_in(2, 24'h0000F0, 1'b0);
        run_conv(3, 24'h000B12, 1'b0);
        @(negedge clk);
        set_in(2, 24'h000087, 1'b1);
        @(negedge clk);
        set_in(2, 24'h000087, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_bin",  bin_of(2), 32'd0);
        chk("midrst_busy", 32'(busy_of(2)), 32'd0);
        chk("midrst_done", 32'(done_of(2)), 32'd0);
        chk("midrst_err3", 32'(err_of(3)), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_of(2)) extra++;
        end
        chk("midrst_no_done", 32'(extra), 32'd0);
        run_conv(2, 24'h000087, 1'b0);

        // Exhaustive sweeps
        for (int v = 0; v < 100; v++) run_conv(2, to_bcd(v, 2), 1'b0);
        for (int v = 0; v < 1000; v++) run_conv(3, to_bcd(v, 3), 1'b0);

        // Random mix across widths, occasionally with illegal digits
        for (int k = 0; k < 150; k++) begin
            rn = int'($urandom_range(2, 4));
            rb = '0;
            for (int i = 0; i < rn; i++) begin
                if ($urandom_range(0, 19) == 0) rb[4*i +: 4] = 4'($urandom_range(10, 15));
                else                            rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            run_conv(rn, rb, ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
